// File: rtl/id_stream_tx_if.sv
// Byte stream channel carrying identifier characters from the transmitter to a sink.
// The master presents char_out/char_valid, and the slave answers with char_ready.
interface id_stream_tx_if;
   logic [7:0] char_out;
   logic       char_valid;
   logic       char_ready;

   modport master (output char_out, output char_valid, input char_ready);
   modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/id_stream_tx.sv
// Identifier stream generator: emits letters, then digits, then a terminator byte,
// one byte per valid/ready transfer, for each accepted start command.
module id_stream_tx #(
   parameter int unsigned MAX_ALPHA = 8,
   parameter int unsigned MAX_DIGIT = 8,
   parameter logic [7:0]  TERM_CHAR = 8'd32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           alpha_len,
   input  logic [3:0]           digit_len,
   input  logic [4:0]           first_alpha,
   input  logic [3:0]           first_digit,
   input  logic                 upper,
   id_stream_tx_if.master       tx,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [1:0] {S_IDLE, S_ALPHA, S_DIGIT, S_TERM} state_t;

   localparam logic [3:0] LP_MAX_ALPHA = 4'(MAX_ALPHA);
   localparam logic [3:0] LP_MAX_DIGIT = 4'(MAX_DIGIT);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_alpha_len;
   logic [3:0] r_digit_len;
   logic [4:0] r_idx;
   logic [3:0] r_dig;
   logic [3:0] r_cnt;
   logic       r_upper;
   logic       r_done;
   logic       r_err;

   logic       w_xfer;
   logic       w_bad;
   logic       w_accept;
   logic [3:0] w_cnt_inc;
   logic [7:0] w_alpha_base;

   assign w_xfer       = tx.char_valid & tx.char_ready;
   assign w_cnt_inc    = r_cnt + 4'd1;
   assign w_alpha_base = r_upper ? 8'd65 : 8'd97;
   // start is ignored while busy and during the done cycle
   assign w_accept     = (r_state == S_IDLE) & start & ~r_done;
   assign w_bad        = (alpha_len == 4'd0) || (alpha_len > LP_MAX_ALPHA) ||
                         (digit_len > LP_MAX_DIGIT) || (first_alpha > 5'd25) ||
                         (first_digit > 4'd9);

   assign done = r_done;
   assign err  = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      w_next        = r_state;
      tx.char_out   = 8'd0;
      tx.char_valid = 1'b0;
      busy          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_bad) w_next = S_ALPHA;
         end
         S_ALPHA: begin
            tx.char_valid = 1'b1;
            busy          = 1'b1;
            tx.char_out   = w_alpha_base + {3'b000, r_idx};
            if (w_xfer && (w_cnt_inc == r_alpha_len))
               w_next = (r_digit_len == 4'd0) ? S_TERM : S_DIGIT;
         end
         S_DIGIT: begin
            tx.char_valid = 1'b1;
            busy          = 1'b1;
            tx.char_out   = 8'd48 + {4'b0000, r_dig};
            if (w_xfer && (w_cnt_inc == r_digit_len)) w_next = S_TERM;
         end
         S_TERM: begin
            tx.char_valid = 1'b1;
            busy          = 1'b1;
            tx.char_out   = TERM_CHAR;
            if (w_xfer) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alpha_len <= 4'd0;
         r_digit_len <= 4'd0;
         r_idx       <= 5'd0;
         r_dig       <= 4'd0;
         r_cnt       <= 4'd0;
         r_upper     <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= (r_state == S_TERM) && w_xfer;
         r_err  <= w_accept && w_bad;
         if (w_accept && !w_bad) begin
            r_alpha_len <= alpha_len;
            r_digit_len <= digit_len;
            r_idx       <= first_alpha;
            r_dig       <= first_digit;
            r_upper     <= upper;
            r_cnt       <= 4'd0;
         end else if (w_xfer) begin
            // the transfer counter restarts at each phase change
            r_cnt <= (w_next == r_state) ? w_cnt_inc : 4'd0;
            if (r_state == S_ALPHA) r_idx <= (r_idx == 5'd25) ? 5'd0 : r_idx + 5'd1;
            if (r_state == S_DIGIT) r_dig <= (r_dig == 4'd9) ? 4'd0 : r_dig + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_id_stream_tx.sv
// Self-checking bench for id_stream_tx: scoreboard of expected bytes built per command,
// compared against bytes captured on each valid/ready transfer.
module tb_id_stream_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] alpha_len = 4'd0;
   logic [3:0] digit_len = 4'd0;
   logic [4:0] first_alpha = 5'd0;
   logic [3:0] first_digit = 4'd0;
   logic       upper = 1'b0;
   logic       busy, done, err;

   id_stream_tx_if bus ();

   id_stream_tx #(.MAX_ALPHA(8), .MAX_DIGIT(8), .TERM_CHAR(8'd32)) dut (
      .clk(clk), .reset(reset), .start(start), .alpha_len(alpha_len),
      .digit_len(digit_len), .first_alpha(first_alpha), .first_digit(first_digit),
      .upper(upper), .tx(bus), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         obs_k[$];
   bit         done_seen;
   int         done_k;
   int         stall_viol;
   bit         err_seen;

   // Reference model: byte sequence a correct transmitter must produce.
   function automatic void push_expected(input int a, input int d, input int fa,
                                         input int fd, input bit up);
      for (int i = 0; i < a; i++) exp_q.push_back(8'((up ? 65 : 97) + ((fa + i) % 26)));
      for (int i = 0; i < d; i++) exp_q.push_back(8'(48 + ((fd + i) % 10)));
      exp_q.push_back(8'd32);
   endfunction

   task automatic send_cmd(input int a, input int d, input int fa, input int fd, input bit up);
      @(negedge clk);
      alpha_len = 4'(a); digit_len = 4'(d); first_alpha = 5'(fa);
      first_digit = 4'(fd); upper = up; start = 1'b1;
   endtask

   // Drives char_ready (mode 0: always 1, mode 1: 1,0,0,...) and captures transfers.
   task automatic drain(input int mode, input int poke_at);
      bit         prev_stall = 1'b0;
      logic [7:0] prev_byte  = 8'd0;
      obs_q.delete(); obs_k.delete();
      done_seen = 1'b0; done_k = -1; stall_viol = 0; err_seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         start = (k == poke_at);
         if (k == poke_at) begin
            alpha_len = 4'd0; digit_len = 4'd15; first_alpha = 5'd31; upper = ~upper;
         end
         bus.char_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         #1;
         if (err) err_seen = 1'b1;
         if (done) begin done_seen = 1'b1; done_k = k; break; end
         if (prev_stall && (!bus.char_valid || bus.char_out !== prev_byte)) stall_viol++;
         if (bus.char_valid && bus.char_ready) begin
            obs_q.push_back(bus.char_out);
            obs_k.push_back(k);
         end
         prev_stall = bus.char_valid && !bus.char_ready;
         prev_byte  = bus.char_out;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus.char_ready = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if ({bus.char_out, bus.char_valid, busy, done, err} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got out=%h valid=%b busy=%b done=%b err=%b, want all 0",
                  bus.char_out, bus.char_valid, busy, done, err);
      end
   endtask

   task automatic test_basic(input string name, input int a, input int d, input int fa,
                             input int fd, input bit up);
      int n;
      logic [7:0] e, o;
      push_expected(a, d, fa, fd, up);
      n = exp_q.size();
      send_cmd(a, d, fa, fd, up);
      drain(0, -1);
      n_tests++;
      if (!done_seen || done_k != n) begin
         n_fail++;
         $display("FAIL %s_done_cycle: got seen=%b k=%0d, want k=%0d", name, done_seen, done_k, n);
      end
      for (int i = 0; i < obs_k.size(); i++) begin
         n_tests++;
         if (obs_k[i] != i) begin
            n_fail++;
            $display("FAIL %s_timing[%0d]: got cycle %0d, want %0d", name, i, obs_k[i], i);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_byte: got nothing, want %h", name, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL %s_byte: got %h, want %h", name, o, e);
            end
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_extra: got %0d extra bytes, want 0", name, obs_q.size());
      end
      @(negedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done_pulse: got done=%b busy=%b, want 0 0", name, done, busy);
      end
   endtask

   task automatic test_stall;
      logic [7:0] e, o;
      push_expected(3, 3, 25, 8, 0);
      send_cmd(3, 3, 25, 8, 0);
      drain(1, -1);
      n_tests++;
      if (!done_seen || stall_viol != 0) begin
         n_fail++;
         $display("FAIL stall_hold: got done=%b violations=%0d, want 1 0", done_seen, stall_viol);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall_byte: got %h, want %h", o, e);
         end
      end
   endtask

   task automatic test_errors;
      int cmds[5][4] = '{'{0, 3, 0, 0}, '{3, 9, 0, 0}, '{3, 3, 26, 0},
                         '{9, 0, 0, 0}, '{3, 3, 0, 10}};
      for (int c = 0; c < 5; c++) begin
         send_cmd(cmds[c][0], cmds[c][1], cmds[c][2], cmds[c][3], 0);
         @(negedge clk); start = 1'b0; #1;
         n_tests++;
         if (err !== 1'b1 || busy !== 1'b0 || bus.char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cmd%0d: got err=%b busy=%b valid=%b, want 1 0 0",
                     c, err, busy, bus.char_valid);
         end
         @(negedge clk); #1;
         n_tests++;
         if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse%0d: got err=%b busy=%b, want 0 0", c, err, busy);
         end
      end
   endtask

   task automatic test_reset_mid;
      send_cmd(2, 5, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); start = 1'b0; bus.char_ready = 1'b1;
      end
      @(negedge clk); bus.char_ready = 1'b0; #1;
      n_tests++;
      if (bus.char_out !== 8'h31 || !busy) begin
         n_fail++;
         $display("FAIL mid_digit: got out=%h busy=%b, want 31 1", bus.char_out, busy);
      end
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if ({bus.char_out, bus.char_valid, busy, done, err} !== 12'd0) begin
         n_fail++;
         $display("FAIL async_reset: got out=%h valid=%b busy=%b, want all 0",
                  bus.char_out, bus.char_valid, busy);
      end
      @(negedge clk); reset = 1'b0;
      exp_q.delete();
      push_expected(3, 3, 25, 8, 0);
      send_cmd(3, 3, 25, 8, 0);
      drain(0, 3);
      n_tests++;
      if (!done_seen || err_seen || obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL restart_busy_start: got done=%b err=%b bytes=%0d, want 1 0 %0d",
                  done_seen, err_seen, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [7:0] e = exp_q.pop_front();
         logic [7:0] o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL restart_byte: got %h, want %h", o, e);
         end
      end
      exp_q.delete();
   endtask

   // Recognizer model: asserts on digits following letters, clears on anything else.
   task automatic test_loopback;
      bit exp_m[$] = '{0, 0, 1, 1, 1, 1, 0};
      bit seen_alpha = 1'b0;
      bit m;
      int hits = 0;
      send_cmd(2, 4, 3, 7, 0);
      drain(0, -1);
      n_tests++;
      if (obs_q.size() != exp_m.size()) begin
         n_fail++;
         $display("FAIL loop_len: got %0d bytes, want %0d", obs_q.size(), exp_m.size());
      end
      while (obs_q.size() > 0 && exp_m.size() > 0) begin
         logic [7:0] b = obs_q.pop_front();
         bit e = exp_m.pop_front();
         if (b >= 8'h61 && b <= 8'h7a) begin seen_alpha = 1'b1; m = 1'b0; end
         else if (b >= 8'h30 && b <= 8'h39 && seen_alpha) m = 1'b1;
         else begin seen_alpha = 1'b0; m = 1'b0; end
         hits += int'(m);
         n_tests++;
         if (m !== e) begin
            n_fail++;
            $display("FAIL loop_match: byte %h got match=%b, want %b", b, m, e);
         end
      end
      n_tests++;
      if (hits != 4) begin
         n_fail++;
         $display("FAIL loop_hits: got %0d, want 4", hits);
      end
   endtask

   initial begin
      bus.char_ready = 1'b0;
      test_reset();
      test_basic("basic", 3, 3, 25, 8, 0);
      test_basic("upper_nodig", 3, 0, 25, 8, 1);
      test_basic("max_wrap", 8, 8, 20, 5, 1);
      test_stall();
      test_errors();
      test_reset_mid();
      test_loopback();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
